reg_slice_pipe: RTL and testbench

- Parametrised successor to the single-stage valid/ready register slice.
- Chains STAGES slice stages between a slave (s_*) and master (m_*) stream.
- MODE selects the slice type: pass-through, forward-registered, or full skid.
- Adds a synchronous flush, an occupancy count and an idle flag.
- Used to break timing paths on long stream routes and to retime a stream across a configurable number of cycles.

---
 rtl/reg_slice_pipe_if.sv | 14 +
 rtl/reg_slice_pipe.sv | 162 ++++++++++++++++
 tb/tb_reg_slice_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_slice_pipe_if.sv
// Valid/ready stream bundle used on both the upstream and downstream
// sides of reg_slice_pipe.
interface reg_slice_pipe_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    // producer: drives valid/data, observes ready
    modport master (output data, output valid, input ready);
    // consumer: observes valid/data, drives ready
    modport slave (input data, input valid, output ready);
endinterface

// File: rtl/reg_slice_pipe.sv
// Chain of STAGES valid/ready register slices between stream s and
// stream m. MODE 0 is a wire, MODE 1 registers valid/data only, MODE 2
// is a fully registered two-entry skid slice. Adds a synchronous flush,
// a held-beat occupancy count and an idle flag.
module reg_slice_pipe #(
    parameter  int DATA_WIDTH = 8,
    parameter  int STAGES     = 2,
    parameter  int MODE       = 2,
    localparam int CNT_W      = $clog2(2*STAGES+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    reg_slice_pipe_if.slave  s,
    reg_slice_pipe_if.master m,
    output logic [CNT_W-1:0] occupancy,
    output logic             idle
);

    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("reg_slice_pipe: STAGES must be within 1..8");
    end
    if (MODE < 0 || MODE > 2) begin : g_bad_mode
        $error("reg_slice_pipe: MODE must be 0, 1 or 2");
    end

    assign idle = (occupancy == '0) && !s.valid;

    if (MODE == 0) begin : g_pass
        assign m.data    = s.data;
        assign m.valid   = s.valid;
        assign s.ready   = m.ready;
        assign occupancy = '0;

        logic unused_pass;
        assign unused_pass = &{1'b0, clk, rst, flush};
    end else begin : g_pipe
        logic             s_fire;
        logic             m_fire;
        logic [CNT_W-1:0] occ_q;

        for (genvar g = 0; g < STAGES; g++) begin : g_stage
            logic                  in_vld;
            logic [DATA_WIDTH-1:0] in_dat;
            logic                  in_rdy;
            logic                  out_vld;
            logic [DATA_WIDTH-1:0] out_dat;
            logic                  out_rdy;

            if (g == 0) begin : g_head
                assign in_vld = s.valid;
                assign in_dat = s.data;
            end else begin : g_link
                assign in_vld = g_stage[g-1].out_vld;
                assign in_dat = g_stage[g-1].out_dat;
            end

            if (g == STAGES-1) begin : g_tail
                assign out_rdy = m.ready;
            end else begin : g_chain
                assign out_rdy = g_stage[g+1].in_rdy;
            end

            if (MODE == 1) begin : g_fwd
                logic                  vld_q;
                logic [DATA_WIDTH-1:0] dat_q;

                // the register can take a new beat when empty or draining
                assign in_rdy  = out_rdy | ~vld_q;
                assign out_vld = vld_q;
                assign out_dat = dat_q;

                // stage valid: flush empties, otherwise reload when ready
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst)        vld_q <= 1'b0;
                    else if (flush)  vld_q <= 1'b0;
                    else if (in_rdy) vld_q <= in_vld;
                end

                // payload capture (no reset; don't-care while invalid)
                always_ff @(posedge clk) begin
                    if (in_rdy && in_vld) dat_q <= in_dat;
                end
            end else begin : g_skid
                logic                  main_vld_q, main_vld_d;
                logic                  skid_vld_q, skid_vld_d;
                logic [DATA_WIDTH-1:0] main_dat_q, main_dat_d;
                logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;
                logic                  rdy_q;
                logic                  in_fire;
                logic                  out_fire;

                assign in_fire  = in_vld & rdy_q;
                assign out_fire = main_vld_q & out_rdy;
                assign in_rdy   = rdy_q;
                assign out_vld  = main_vld_q;
                assign out_dat  = main_dat_q;

                // main/skid steering; rdy_q low guarantees no accept into a full skid
                always_comb begin
                    main_vld_d = main_vld_q;
                    main_dat_d = main_dat_q;
                    skid_vld_d = skid_vld_q;
                    skid_dat_d = skid_dat_q;
                    if (!main_vld_q || out_fire) begin
                        if (skid_vld_q) begin
                            main_vld_d = 1'b1;
                            main_dat_d = skid_dat_q;
                            skid_vld_d = in_fire;
                            skid_dat_d = in_dat;
                        end else begin
                            main_vld_d = in_fire;
                            if (in_fire) main_dat_d = in_dat;
                        end
                    end else if (in_fire) begin
                        skid_vld_d = 1'b1;
                        skid_dat_d = in_dat;
                    end
                    if (flush) begin
                        main_vld_d = 1'b0;
                        skid_vld_d = 1'b0;
                    end
                end

                // valid flags and registered ready (ready held low through flush)
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        main_vld_q <= 1'b0;
                        skid_vld_q <= 1'b0;
                        rdy_q      <= 1'b0;
                    end else begin
                        main_vld_q <= main_vld_d;
                        skid_vld_q <= skid_vld_d;
                        rdy_q      <= ~skid_vld_d & ~flush;
                    end
                end

                // payload registers (no reset)
                always_ff @(posedge clk) begin
                    main_dat_q <= main_dat_d;
                    skid_dat_q <= skid_dat_d;
                end
            end
        end

        assign s.ready   = g_stage[0].in_rdy & ~flush;
        assign m.valid   = g_stage[STAGES-1].out_vld;
        assign m.data    = g_stage[STAGES-1].out_dat;
        assign s_fire    = s.valid & s.ready;
        assign m_fire    = m.valid & m.ready;
        assign occupancy = occ_q;

        // held-beat counter: +1 per accept, -1 per delivery
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)                   occ_q <= '0;
            else if (flush)             occ_q <= '0;
            else if (s_fire && !m_fire) occ_q <= occ_q + CNT_W'(1);
            else if (!s_fire && m_fire) occ_q <= occ_q - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_reg_slice_pipe.sv
// Directed bench for reg_slice_pipe: MODE 2 / STAGES 2, MODE 1 / STAGES 3
// and MODE 0 instances share clock and reset.
module tb_reg_slice_pipe;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush2, flush1, flush0;
    logic [2:0] occ2, occ1, occ0;
    logic       idle2, idle1, idle0;

    int n_cmp = 0;
    int n_err = 0;

    int         sent, got, cyc, nacc;
    int         t_acc, t_mv, t_m0, t_m_last, t_low, t_rdy;
    logic [7:0] exp_d;
    logic [7:0] stall_data;
    logic       stall_prev, sfire, found;
    logic [7:0] sb_q[$];

    logic       f_v [4];
    logic       f_r [4];
    logic [7:0] f_d [4];

    reg_slice_pipe_if #(.DATA_WIDTH(DW)) s2 ();
    reg_slice_pipe_if #(.DATA_WIDTH(DW)) m2 ();
    reg_slice_pipe_if #(.DATA_WIDTH(DW)) s1 ();
    reg_slice_pipe_if #(.DATA_WIDTH(DW)) m1 ();
    reg_slice_pipe_if #(.DATA_WIDTH(DW)) s0 ();
    reg_slice_pipe_if #(.DATA_WIDTH(DW)) m0 ();

    reg_slice_pipe #(.DATA_WIDTH(DW), .STAGES(2), .MODE(2)) u_m2 (
        .clk(clk), .rst(rst_n), .flush(flush2), .s(s2), .m(m2),
        .occupancy(occ2), .idle(idle2));
    reg_slice_pipe #(.DATA_WIDTH(DW), .STAGES(3), .MODE(1)) u_m1 (
        .clk(clk), .rst(rst_n), .flush(flush1), .s(s1), .m(m1),
        .occupancy(occ1), .idle(idle1));
    reg_slice_pipe #(.DATA_WIDTH(DW), .STAGES(2), .MODE(0)) u_m0 (
        .clk(clk), .rst(rst_n), .flush(flush0), .s(s0), .m(m0),
        .occupancy(occ0), .idle(idle0));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        flush2 = 1'b0; flush1 = 1'b0; flush0 = 1'b0;
        s2.valid = 1'b0; s2.data = '0; m2.ready = 1'b0;
        s1.valid = 1'b0; s1.data = '0; m1.ready = 1'b0;
        s0.valid = 1'b0; s0.data = '0; m0.ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #2;
        check_val("rst_m2_valid", m2.valid, 0);
        check_val("rst_occ2", occ2, 0);
        check_val("rst_s2_ready", s2.ready, 0);
        check_val("rst_idle2", idle2, 1);
        check_val("rst_m1_valid", m1.valid, 0);
        check_val("rst_occ1", occ1, 0);
        rst_n = 1'b1;
        #1 check_val("rel_s2_ready_before_edge", s2.ready, 0);
        tick();
        check_val("rel_s2_ready_first_edge", s2.ready, 1);

        // ---------------- A: MODE 2 streaming 0x01..0x10 ----------------
        m2.ready = 1'b1;
        sent = 0; got = 0; cyc = 0; exp_d = 8'h01;
        t_acc = -1; t_mv = -1; t_m0 = -1; t_m_last = -1;
        while (got < 16 && cyc < 100) begin
            s2.valid = (sent < 16);
            s2.data  = 8'(sent + 1);
            @(negedge clk);
            if (m2.valid && t_mv < 0) t_mv = cyc;
            if (m2.valid && m2.ready) begin
                check_val("A_order", m2.data, exp_d);
                exp_d++;
                got++;
                if (t_m0 < 0) t_m0 = cyc;
                t_m_last = cyc;
            end
            if (s2.valid && s2.ready) begin
                if (t_acc < 0) t_acc = cyc;
                if (sent == 7) check_val("A_occ_steady", occ2, 2);
                sent++;
            end
            tick();
            cyc++;
        end
        s2.valid = 1'b0;
        check_val("A_count", got, 16);
        check_val("A_latency", t_mv - t_acc, 2);
        check_val("A_back_to_back", t_m_last - t_m0, 15);
        check_val("A_occ_empty", occ2, 0);
        check_val("A_idle", idle2, 1);

        // ---------------- B: MODE 2 backpressure fill and drain ----------------
        m2.ready = 1'b0;
        s2.valid = 1'b1;
        nacc = 0; cyc = 0; t_low = -1;
        for (int i = 0; i < 8; i++) begin
            s2.data = 8'(8'h21 + nacc);
            @(negedge clk);
            if (!s2.ready && t_low < 0) t_low = cyc;
            if (s2.valid && s2.ready) nacc++;
            tick();
            cyc++;
        end
        check_val("B_accepted", nacc, 4);
        check_val("B_first_stall_cycle", t_low, 4);
        check_val("B_occ_full", occ2, 4);
        check_val("B_s_ready_low", s2.ready, 0);
        check_val("B_not_idle", idle2, 0);
        s2.valid = 1'b0;
        m2.ready = 1'b1;
        got = 0; cyc = 0; exp_d = 8'h21; t_m0 = -1; t_rdy = -1;
        while ((got < 4 || t_rdy < 0) && cyc < 50) begin
            @(negedge clk);
            if (s2.ready && t_rdy < 0) t_rdy = cyc;
            if (m2.valid && m2.ready) begin
                check_val("B_drain_order", m2.data, exp_d);
                exp_d++;
                got++;
                if (t_m0 < 0) t_m0 = cyc;
            end
            tick();
            cyc++;
        end
        check_val("B_drain_count", got, 4);
        // registered ready walks back one stage per cycle from the output
        check_val("B_ready_return", t_rdy - t_m0, 2);
        check_val("B_occ_empty", occ2, 0);

        // ---------------- C: MODE 2 flush with 3 held beats ----------------
        m2.ready = 1'b0;
        s2.valid = 1'b1;
        nacc = 0; cyc = 0;
        while (nacc < 3 && cyc < 20) begin
            s2.data = 8'(8'h31 + nacc);
            @(negedge clk);
            if (s2.valid && s2.ready) nacc++;
            tick();
            cyc++;
        end
        check_val("C_held", nacc, 3);
        check_val("C_occ_before", occ2, 3);
        flush2 = 1'b1;
        s2.data = 8'h3F;
        @(negedge clk);
        check_val("C_s_ready_in_flush", s2.ready, 0);
        tick();
        flush2 = 1'b0;
        s2.valid = 1'b0;
        check_val("C_m_valid_after", m2.valid, 0);
        check_val("C_occ_after", occ2, 0);
        check_val("C_s_ready_after", s2.ready, 0);
        tick();
        check_val("C_s_ready_return", s2.ready, 1);
        s2.valid = 1'b1;
        s2.data  = 8'h40;
        m2.ready = 1'b1;
        @(negedge clk);
        tick();
        s2.valid = 1'b0;
        found = 1'b0; cyc = 0;
        while (!found && cyc < 10) begin
            @(negedge clk);
            if (m2.valid) begin
                check_val("C_first_after_flush", m2.data, 8'h40);
                found = 1'b1;
            end
            tick();
            cyc++;
        end
        check_val("C_beat_seen", found, 1);
        check_val("C_occ_final", occ2, 0);

        // ---------------- D: MODE 1 random traffic, scoreboard ----------------
        sent = 0; got = 0; cyc = 0; stall_prev = 1'b0; stall_data = '0;
        s1.valid = 1'b0;
        while (got < 1000 && cyc < 20000) begin
            if (!s1.valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                s1.valid = 1'b1;
                s1.data  = 8'($urandom);
            end
            m1.ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_val("D_occ_model", occ1, sb_q.size());
            check_val("D_occ_bound", occ1 <= 3'd3, 1);
            if (stall_prev) begin
                check_val("D_hold_valid", m1.valid, 1);
                check_val("D_hold_data", m1.data, stall_data);
            end
            stall_prev = m1.valid && !m1.ready;
            stall_data = m1.data;
            if (m1.valid && m1.ready) begin
                check_val("D_sb_nonempty", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) check_val("D_data", m1.data, sb_q.pop_front());
                got++;
            end
            sfire = s1.valid && s1.ready;
            if (sfire) begin
                sb_q.push_back(s1.data);
                sent++;
            end
            tick();
            cyc++;
            if (sfire) s1.valid = 1'b0;
        end
        s1.valid = 1'b0;
        check_val("D_count", got, 1000);

        // ---------------- D2: MODE 1 flush held two cycles ----------------
        m1.ready = 1'b0;
        s1.valid = 1'b1;
        nacc = 0; cyc = 0;
        while (nacc < 3 && cyc < 20) begin
            s1.data = 8'(8'h61 + nacc);
            @(negedge clk);
            if (s1.valid && s1.ready) nacc++;
            tick();
            cyc++;
        end
        check_val("D2_occ_full", occ1, 3);
        flush1 = 1'b1;
        m1.ready = 1'b1;
        s1.data = 8'h6F;
        @(negedge clk);
        check_val("D2_s_ready_flush", s1.ready, 0);
        check_val("D2_deliver_valid", m1.valid, 1);
        check_val("D2_deliver_data", m1.data, 8'h61);
        tick();
        m1.ready = 1'b0;
        check_val("D2_m_valid_1", m1.valid, 0);
        check_val("D2_occ_1", occ1, 0);
        @(negedge clk);
        check_val("D2_s_ready_held", s1.ready, 0);
        tick();
        check_val("D2_m_valid_2", m1.valid, 0);
        check_val("D2_occ_2", occ1, 0);
        flush1 = 1'b0;
        s1.valid = 1'b0;

        // ---------------- E: reset mid-stream (MODE 2) ----------------
        m2.ready = 1'b0;
        s2.valid = 1'b1;
        nacc = 0; cyc = 0;
        while (nacc < 3 && cyc < 20) begin
            s2.data = 8'(8'h51 + nacc);
            @(negedge clk);
            if (s2.valid && s2.ready) nacc++;
            tick();
            cyc++;
        end
        s2.valid = 1'b0;
        check_val("E_m_valid_before", m2.valid, 1);
        check_val("E_occ_before", occ2, 3);
        #3 rst_n = 1'b0;
        #1;
        check_val("E_m_valid_async", m2.valid, 0);
        check_val("E_occ_async", occ2, 0);
        check_val("E_s_ready_async", s2.ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("E_s_ready_released", s2.ready, 0);
        tick();
        check_val("E_s_ready_edge", s2.ready, 1);
        check_val("E_no_valid_glitch", m2.valid, 0);
        s2.valid = 1'b1;
        s2.data  = 8'h5A;
        m2.ready = 1'b1;
        @(negedge clk);
        tick();
        s2.valid = 1'b0;
        found = 1'b0; cyc = 0;
        while (!found && cyc < 10) begin
            @(negedge clk);
            if (m2.valid) begin
                check_val("E_restart_data", m2.data, 8'h5A);
                found = 1'b1;
            end
            tick();
            cyc++;
        end
        check_val("E_restart_seen", found, 1);

        // ---------------- F: MODE 0 pass-through vectors ----------------
        f_v[0] = 1'b1; f_r[0] = 1'b1; f_d[0] = 8'hA5;
        f_v[1] = 1'b1; f_r[1] = 1'b0; f_d[1] = 8'h3C;
        f_v[2] = 1'b0; f_r[2] = 1'b1; f_d[2] = 8'hFF;
        f_v[3] = 1'b0; f_r[3] = 1'b0; f_d[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            s0.valid = f_v[i];
            s0.data  = f_d[i];
            m0.ready = f_r[i];
            flush0   = f_v[i];
            #1;
            check_val("F_m_valid", m0.valid, f_v[i]);
            check_val("F_m_data", m0.data, f_d[i]);
            check_val("F_s_ready", s0.ready, f_r[i]);
            check_val("F_occ", occ0, 0);
            check_val("F_idle", idle0, !f_v[i]);
            tick();
        end
        flush0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
